// File: rtl/data_sram_resp_pkg.sv
// Shared types and helpers for the data-SRAM responder: FSM encodings, the latched
// request record and the address range check.
package data_sram_resp_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  // 33-bit compare keeps the bound exact even when the array spans the whole space.
  function automatic logic addr_in_range(input logic [31:0] off, input int unsigned depth_log2);
    return ({1'b0, off} < (33'd4 << depth_log2));
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data-SRAM port bundle between the EX/MEM requester and the on-chip responder.
interface data_sram_resp_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
  logic        access_err;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq_mem,
    input  access_err
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq_mem,
    output access_err
  );

endinterface

// File: rtl/data_sram_array.sv
// 2**DEPTH_LOG2 x 32 synchronous RAM with byte write enables and a registered
// read-before-write output; clr_i zeroes the output word instead of reading.
module data_sram_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  clr_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [3:0]            wen_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_d, rdata_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (req_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr_i) begin
      rdata_d = '0;
    end else if (req_i) begin
      rdata_d = mem[idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the CPU data-SRAM port: range check, optional wait-state FSM and
// stall request, with the storage itself in data_sram_array.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  data_sram_resp_if.slave bus
);

  localparam logic [CntW-1:0] CntInit =
      (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

  logic [0:0]      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  sram_req_t       req_d, req_q;
  logic            err_d, err_q;

  sram_req_t       bus_req, cur_req;
  logic            commit, commit_ok, in_range;
  logic [31:0]     off;

  assign bus_req = '{wen: bus.data_sram_wen, addr: bus.data_sram_addr,
                     wdata: bus.data_sram_wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cur_req = bus_req;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            req_d   = bus_req;
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
      end
      default: begin
        // Bus inputs are ignored while waiting; only the latched request matters.
        cur_req = req_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  assign off       = cur_req.addr - BASE_ADDR;
  assign in_range  = addr_in_range(off, DEPTH_LOG2);
  assign commit_ok = commit & ~rst;
  assign err_d     = commit_ok & ~in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  data_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .req_i  (commit_ok & in_range),
    .clr_i  (commit_ok & ~in_range),
    .idx_i  (off[DEPTH_LOG2+1:2]),
    .wen_i  (cur_req.wen),
    .wdata_i(cur_req.wdata),
    .rdata_o(bus.data_sram_rdata)
  );

  assign bus.stallreq_mem = ~rst &
      (((state_q == StIdle) & bus.data_sram_en & (WAIT_CYCLES != 0)) |
       ((state_q == StWait) & (cnt_q != '0)));
  assign bus.access_err   = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed and scoreboard bench for data_sram_resp with zero and three wait states.
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_sram_resp_if if0 ();
  data_sram_resp_if if3 ();

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(if0)
  );
  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(if3)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Zero-wait access: drive at negedge, return just after the committing edge.
  task automatic acc0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    if0.data_sram_en    = en;
    if0.data_sram_wen   = wen;
    if0.data_sram_addr  = addr;
    if0.data_sram_wdata = wdata;
    #1;
    chk("w0_stall", {31'b0, if0.stallreq_mem}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Wait-state access held on the bus until stall drops; optionally scrambles the
  // bus during the wait cycles. Returns one negedge after the commit edge.
  task automatic acc3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic scramble, output int stalls);
    @(negedge clk);
    if3.data_sram_en    = 1'b1;
    if3.data_sram_wen   = wen;
    if3.data_sram_addr  = addr;
    if3.data_sram_wdata = wdata;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!if3.stallreq_mem) break;
      stalls++;
      @(negedge clk);
      if (scramble) begin
        if3.data_sram_addr  = addr ^ 32'h4;
        if3.data_sram_wdata = ~wdata;
        if3.data_sram_wen   = ~wen;
      end
    end
    @(negedge clk);
    if3.data_sram_en = 1'b0;
    #1;
  endtask

  logic [31:0] model_mem [16];
  logic [31:0] exp_rd;
  logic        exp_er;
  int          stalls;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'h1122_3344, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 4'h0, 32'h10,   32'h0,         1'b1, 32'h1122_3344, 1'b0};
    vecs[2]  = '{1'b1, 4'h4, 32'h10,   32'h00AB_0000, 1'b1, 32'h1122_3344, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 32'h10,   32'h0,         1'b1, 32'h11AB_3344, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h10,   32'h0,         1'b1, 32'h11AB_3344, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 32'h1000, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 4'hF, 32'h0,    32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 4'hF, 32'h1000, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 4'h0, 32'h0,    32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 4'hF, 32'h40,   32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 4'h0, 32'h40,   32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b1, 4'h3, 32'h42,   32'h0000_BEEF, 1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[13] = '{1'b1, 4'h0, 32'h40,   32'h0,         1'b1, 32'hA5A5_BEEF, 1'b0};
    vecs[14] = '{1'b1, 4'h8, 32'h40,   32'h7700_0000, 1'b1, 32'hA5A5_BEEF, 1'b0};
    vecs[15] = '{1'b1, 4'h0, 32'h40,   32'h0,         1'b1, 32'h77A5_BEEF, 1'b0};

    rst0 = 1'b1;
    rst3 = 1'b1;
    if0.data_sram_en = 1'b0; if0.data_sram_wen = '0;
    if0.data_sram_addr = '0; if0.data_sram_wdata = '0;
    if3.data_sram_en = 1'b0; if3.data_sram_wen = '0;
    if3.data_sram_addr = '0; if3.data_sram_wdata = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("rst_rdata0", if0.data_sram_rdata, 32'h0);
    chk("rst_err0", {31'b0, if0.access_err}, 32'h0);
    chk("rst_rdata3", if3.data_sram_rdata, 32'h0);
    chk("rst_stall3", {31'b0, if3.stallreq_mem}, 32'h0);

    // Zero-wait directed table.
    foreach (vecs[i]) begin
      acc0(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rdata) chk($sformatf("vec%0d_rdata", i), if0.data_sram_rdata,
                                 vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, if0.access_err}, {31'b0, vecs[i].exp_err});
    end

    // Request presented together with reset must be dropped.
    @(negedge clk);
    rst0 = 1'b1;
    if0.data_sram_en = 1'b1; if0.data_sram_wen = 4'hF;
    if0.data_sram_addr = 32'h40; if0.data_sram_wdata = 32'h0;
    @(negedge clk);
    rst0 = 1'b0;
    if0.data_sram_en = 1'b0;
    #1;
    chk("rst0_rdata", if0.data_sram_rdata, 32'h0);
    acc0(1'b1, 4'h0, 32'h40, 32'h0);
    chk("rst0_en_ignored", if0.data_sram_rdata, 32'h77A5_BEEF);

    // Scoreboard: random traffic over 16 words at 0x100, some out of range.
    for (int k = 0; k < 16; k++) begin
      model_mem[k] = $urandom;
      acc0(1'b1, 4'hF, 32'h100 + 32'(4 * k), model_mem[k]);
    end
    exp_rd = '0;
    for (int n = 0; n < 150; n++) begin
      logic        en;
      logic [3:0]  wen;
      logic [31:0] wd, addr;
      int          k;
      logic        oor;
      en   = (n == 0) || ($urandom_range(0, 4) != 0);
      wen  = 4'($urandom_range(0, 15));
      wd   = $urandom;
      k    = $urandom_range(0, 15);
      oor  = ($urandom_range(0, 7) == 0);
      addr = (oor ? 32'h1000 : 32'h100) + 32'(4 * k) + 32'($urandom_range(0, 3));
      exp_er = 1'b0;
      if (en) begin
        if (oor) begin
          exp_rd = '0;
          exp_er = 1'b1;
        end else begin
          exp_rd = model_mem[k];
          for (int b = 0; b < 4; b++) begin
            if (wen[b]) model_mem[k][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
      acc0(en, wen, addr, wd);
      chk($sformatf("rand%0d_rdata", n), if0.data_sram_rdata, exp_rd);
      chk($sformatf("rand%0d_err", n), {31'b0, if0.access_err}, {31'b0, exp_er});
    end
    @(negedge clk);
    if0.data_sram_en = 1'b0;

    // Three wait states: latency and stall length.
    acc3(4'hF, 32'h20, 32'h5555_AAAA, 1'b0, stalls);
    chk("w3_wr_stalls", 32'(stalls), 32'd3);
    acc3(4'h0, 32'h20, 32'h0, 1'b0, stalls);
    chk("w3_rd_stalls", 32'(stalls), 32'd3);
    chk("w3_rd_rdata", if3.data_sram_rdata, 32'h5555_AAAA);
    chk("w3_stall_after", {31'b0, if3.stallreq_mem}, 32'h0);
    // Bus changes during the wait are ignored.
    acc3(4'h0, 32'h20, 32'h0, 1'b1, stalls);
    chk("w3_latched_rdata", if3.data_sram_rdata, 32'h5555_AAAA);
    acc3(4'h0, 32'h24, 32'h0, 1'b0, stalls);
    acc3(4'h0, 32'h20, 32'h0, 1'b0, stalls);
    chk("w3_no_scramble_wr", if3.data_sram_rdata, 32'h5555_AAAA);

    // Out of range with wait states.
    acc3(4'hF, 32'h0, 32'h0F0F_0F0F, 1'b0, stalls);
    acc3(4'h0, 32'h1000, 32'h0, 1'b0, stalls);
    chk("w3_oor_rdata", if3.data_sram_rdata, 32'h0);
    chk("w3_oor_err", {31'b0, if3.access_err}, 32'h1);
    @(negedge clk);
    #1;
    chk("w3_oor_err_pulse", {31'b0, if3.access_err}, 32'h0);
    acc3(4'hF, 32'h1000, 32'hFFFF_FFFF, 1'b0, stalls);
    chk("w3_oor_wr_err", {31'b0, if3.access_err}, 32'h1);
    acc3(4'h0, 32'h0, 32'h0, 1'b0, stalls);
    chk("w3_mem0_kept", if3.data_sram_rdata, 32'h0F0F_0F0F);

    // Reset in the second wait cycle of a write.
    acc3(4'hF, 32'h30, 32'h1357_2468, 1'b0, stalls);
    acc3(4'h0, 32'h30, 32'h0, 1'b0, stalls);
    chk("w3_pre_rst_rdata", if3.data_sram_rdata, 32'h1357_2468);
    @(negedge clk);
    if3.data_sram_en = 1'b1; if3.data_sram_wen = 4'hF;
    if3.data_sram_addr = 32'h30; if3.data_sram_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    if3.data_sram_en = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("w3_rst_stall", {31'b0, if3.stallreq_mem}, 32'h0);
    chk("w3_rst_rdata", if3.data_sram_rdata, 32'h0);
    @(negedge clk);
    #1;
    chk("w3_rst_idle", {31'b0, if3.stallreq_mem}, 32'h0);
    acc3(4'h0, 32'h30, 32'h0, 1'b0, stalls);
    chk("w3_rst_stalls", 32'(stalls), 32'd3);
    chk("w3_rst_no_write", if3.data_sram_rdata, 32'h1357_2468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
